// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory stage: data widths, register-number
// width, FSM encoding, abort fill pattern and the MEM/WB bundle layout.
package mem_access_stage_pkg;

  localparam int ADDRESS_LEN  = 32;
  localparam int REGISTER_LEN = 32;
  localparam int REG_NUM_W    = 4;

  // Load data returned when the ack watchdog abandons an access
  localparam logic [REGISTER_LEN-1:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Write-back bundle carried across an outstanding access
  typedef struct packed {
    logic                   wb_enable;
    logic                   mem_read;
    logic [ADDRESS_LEN-1:0] alu_res;
    logic [REG_NUM_W-1:0]   dest;
  } wb_bundle_t;

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte-address to SRAM word-address translation: subtract the region base
// (mod 2^32), drop the byte offset, keep the low SRAM_ADDR_W word bits.
// Addresses below the base wrap silently.
module mem_addr_xlate
  import mem_access_stage_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] MEM_BASE    = 32'd1024,
  parameter int                     SRAM_ADDR_W = 16
) (
  input  logic [ADDRESS_LEN-1:0] byte_addr,
  output logic [SRAM_ADDR_W-1:0] word_addr
);

  logic [ADDRESS_LEN-1:0] offset;

  // Offset from the base, then word index truncated to the SRAM width
  always_comb begin
    offset    = byte_addr - MEM_BASE;
    word_addr = SRAM_ADDR_W'(offset >> 2);
  end

endmodule

// File: rtl/mem_access_stage.sv
// ARM pipeline memory stage with built-in MEM/WB register. Loads/stores go
// out over a req/ack word-SRAM handshake while the upstream pipe is frozen.
// Optional feature: define MEM_TIMEOUT_EN to add an ack watchdog that aborts
// an access after TIMEOUT_CYCLES cycles and pulses mem_err.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] MEM_BASE       = 32'd1024,
  parameter int                     SRAM_ADDR_W    = 16,
  parameter int                     TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_enable_in,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic [ADDRESS_LEN-1:0]  alu_res_in,
  input  logic [REGISTER_LEN-1:0] val_rm_in,
  input  logic [REG_NUM_W-1:0]    dest_in,
  output logic                    freeze,
  output logic                    wb_enable_out,
  output logic                    mem_read_out,
  output logic [ADDRESS_LEN-1:0]  alu_res_out,
  output logic [REGISTER_LEN-1:0] mem_data_out,
  output logic [REG_NUM_W-1:0]    dest_out,
  output logic                    mem_err,
  output logic                    sram_req,
  output logic                    sram_we,
  output logic [SRAM_ADDR_W-1:0]  sram_addr,
  output logic [REGISTER_LEN-1:0] sram_wdata,
  input  logic [REGISTER_LEN-1:0] sram_rdata,
  input  logic                    sram_ack
);

  mem_state_e             state, state_nxt;
  wb_bundle_t             lat_q;
  logic                   cmd;
  logic                   timeout;
  logic [SRAM_ADDR_W-1:0] xaddr;

  assign cmd = mem_read_in | mem_write_in;

  mem_addr_xlate #(
    .MEM_BASE    (MEM_BASE),
    .SRAM_ADDR_W (SRAM_ADDR_W)
  ) u_xlate (
    .byte_addr (alu_res_in),
    .word_addr (xaddr)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Abort on the last allowed ACCESS cycle unless ack arrives in it
  assign timeout = (state == ST_ACCESS) && !sram_ack &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts ACCESS cycles; cleared whenever not in ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    wd_cnt <= '0;
    else if (state != ST_ACCESS) wd_cnt <= '0;
    else                         wd_cnt <= wd_cnt + CNT_W'(1);
  end

  // One-cycle error pulse, visible in the DONE cycle after an abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_err <= 1'b0;
    else      mem_err <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: DONE always returns to IDLE so the still-present
  // completed command is not issued twice
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd) state_nxt = ST_ACCESS;
      ST_ACCESS: if (sram_ack || timeout) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: freeze covers the accept cycle and all ACCESS cycles; reset
  // gates it so an abandoned access releases the pipe immediately
  always_comb begin
    freeze   = rst && (((state == ST_IDLE) && cmd) || (state == ST_ACCESS));
    sram_req = (state == ST_ACCESS);
  end

  // Latch request and the pending write-back bundle on command accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      lat_q      <= '0;
    end else if ((state == ST_IDLE) && cmd) begin
      sram_addr  <= xaddr;
      sram_wdata <= val_rm_in;
      sram_we    <= mem_write_in & ~mem_read_in;  // read wins if both set
      lat_q      <= '{wb_enable: wb_enable_in, mem_read: mem_read_in,
                      alu_res: alu_res_in, dest: dest_in};
    end
  end

  // MEM/WB register: pass-through in IDLE, completion/abort load in
  // ACCESS, bubble in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_enable_out <= 1'b0;
      mem_read_out  <= 1'b0;
      alu_res_out   <= '0;
      dest_out      <= '0;
      mem_data_out  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cmd) begin
            wb_enable_out <= wb_enable_in;
            mem_read_out  <= 1'b0;
            alu_res_out   <= alu_res_in;
            dest_out      <= dest_in;
          end
        end
        ST_ACCESS: begin
          if (sram_ack) begin
            wb_enable_out <= lat_q.wb_enable;
            mem_read_out  <= lat_q.mem_read;
            alu_res_out   <= lat_q.alu_res;
            dest_out      <= lat_q.dest;
            if (lat_q.mem_read) mem_data_out <= sram_rdata;
          end else if (timeout) begin
            wb_enable_out <= 1'b0;          // squash the failed access
            mem_read_out  <= lat_q.mem_read;
            alu_res_out   <= lat_q.alu_res;
            dest_out      <= lat_q.dest;
            mem_data_out  <= DEAD_BEEF;
          end
        end
        ST_DONE: begin
          wb_enable_out <= 1'b0;
          mem_read_out  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the ARM pipeline: consumes the execute stage's result bundle (ALU result as byte address, Rm value as store data, memory/write-back controls) and performs the data access over a req/ack word-SRAM handshake. It freezes the upstream pipeline while an access is outstanding. It delivers a registered result bundle to the write-back stage, so the MEM/WB pipeline register is built in.

## Interface
- MEM_BASE, 32'd1024, byte address mapped to SRAM word 0
- SRAM_ADDR_W, 16, SRAM word-address width
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with the watchdog macro)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- wb_enable_in  in  1  write-back enable from execute
- mem_read_in  in  1  load command
- mem_write_in  in  1  store command
- alu_res_in  in  32  ALU result; the byte address for memory commands
- val_rm_in  in  32  store data
- dest_in  in  4  destination register number
- freeze  out  1  stall request to IF/ID/EXE and their pipeline registers
- wb_enable_out  out  1  registered write-back enable
- mem_read_out  out  1  registered load flag (WB mux select)
- alu_res_out  out  32  registered ALU result
- mem_data_out  out  32  registered load data
- dest_out  out  4  registered destination
- mem_err  out  1  one-cycle pulse when a watchdog abort occurs
- sram_req  out  1  access request
- sram_we  out  1  1 = write, 0 = read; valid while sram_req = 1
- sram_addr  out  SRAM_ADDR_W  word address
- sram_wdata  out  32  write data
- sram_rdata  in  32  read data; valid in the cycle sram_ack = 1
- sram_ack  in  1  access complete

## Operation
- Address translation: sram_addr = ((alu_res_in - MEM_BASE) >> 2) truncated to SRAM_ADDR_W bits.
  - Modulo-2^32 subtraction.
  - Byte offset bits [1:0] are ignored.
  - Addresses below MEM_BASE wrap silently.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no memory command:
  - Inputs are registered to the outputs at the next edge.
  - freeze = 0; mem_data_out holds its previous value.
- IDLE, mem_read_in | mem_write_in = 1:
  - freeze = 1 combinationally in the same cycle.
  - At the edge: latch address, write data, we (= mem_write_in), wb_enable_in, mem_read_in, alu_res_in and dest_in. Go to ACCESS.
  - If mem_read_in and mem_write_in are both 1, the access is treated as a read.
- ACCESS:
  - sram_req = 1; sram_addr, sram_wdata and sram_we stay stable; freeze = 1.
  - On an edge where sram_ack = 1: capture sram_rdata (reads only; writes leave mem_data_out unchanged), load the latched bundle into the outputs, go to DONE.
- DONE:
  - freeze = 0 and sram_req = 0. Upstream advances at this edge.
  - Inputs are ignored in DONE, because they still carry the completed command. This prevents a double access.
  - Output-bundle registers load a bubble (wb_enable_out = 0, mem_read_out = 0, other output-bundle registers hold). Go to IDLE.
- sram_ack outside ACCESS is ignored.

## Timing
- Reset state: IDLE, freeze = 0, sram_req = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0, all output-bundle registers 0, mem_err = 0.
- Reset mid-ACCESS drops sram_req immediately (asynchronous). The access is abandoned.
- Non-memory latency: 1 cycle, throughput 1 per cycle.
- Memory latency with ack at the k-th ACCESS cycle (k ≥ 1): result is visible at outputs k+1 cycles after the command is first presented. freeze is high for k+1 cycles; the DONE cycle adds one bubble.
- sram_req rises one cycle after the command appears and falls the cycle after ack. Ack in the first ACCESS cycle is legal.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit (clog2 of TIMEOUT_CYCLES+1) counter runs in ACCESS and clears on entry.
  - If TIMEOUT_CYCLES cycles elapse without ack: go to DONE, pulse mem_err for 1 cycle, and force wb_enable_out = 0 (the load is squashed).
  - mem_data_out = 32'hDEAD_BEEF on that abort.
- MEM_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely.
  - mem_err is tied to 0 (port kept).

## Structure
- Shared defines package: ADDRESS_LEN, REGISTER_LEN, the 4-bit register-number width, FSM state encoding (2 bits), and the DEAD_BEEF abort constant.
- One sub-module, mem_addr_xlate: combinational MEM_BASE subtraction, word shift and truncation, reused by the instruction-memory side later.
- FSM, bundle registers and watchdog stay in mem_access_stage.

## Test plan
- ALU op, dest 3, alu_res 0x55, wb 1, no memory command:
  - Next cycle wb_enable_out = 1, alu_res_out = 0x55, dest_out = 3; freeze never asserts.
- Store alu_res 1028, val_rm 0xCAFEF00D, ack on the 2nd ACCESS cycle:
  - sram_addr = 1, sram_we = 1, sram_wdata = 0xCAFEF00D.
  - freeze high 3 cycles; one bubble (wb_enable_out = 0) on the DONE edge.
- Load alu_res 1032, sram_rdata 0x12345678 with ack on the 1st ACCESS cycle:
  - mem_data_out = 0x12345678, mem_read_out = 1, exactly one SRAM request, no re-issue in DONE.
- Load alu_res 0x3FF (below MEM_BASE):
  - sram_addr = 0xFFFF (wrap).
- rst low during ACCESS:
  - sram_req = 0 and freeze = 0 at once.
  - Outputs 0; after release, a new command is accepted normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack:
  - Abort after 4 ACCESS cycles, mem_err pulses once, mem_data_out = 0xDEADBEEF, wb_enable_out = 0.
  - Without the macro, the same stimulus keeps freeze high for 100+ cycles and mem_err stays 0.
